// File: rtl/std_pipe_vr.sv
// std_pipe_vr: DEPTH-stage elastic pipeline register with valid/ready,
// bubble collapsing, synchronous flush and a registered occupancy count.
module std_pipe_vr #(
  parameter int unsigned           DATA_WIDTH       = 1,
  parameter int unsigned           DEPTH            = 2,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET_VALUE = '0,
  parameter bit                    DATA_RESET_EN    = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  if (DEPTH < 1) begin : g_depth_chk
    $error("std_pipe_vr: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0]      v_q;
  logic [DEPTH-1:0]      ld;
  logic [DEPTH-1:0]      src_v;
  logic [DATA_WIDTH-1:0] d_q   [DEPTH];
  logic [DATA_WIDTH-1:0] src_d [DEPTH];
  logic [CW-1:0]         cnt_q;
  logic                  in_xfer;
  logic                  out_xfer;

  // Stage k may load unless it and every stage ahead of it is full
  // while the output is stalled.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ld
    assign ld[k] = o_ready | ~(&v_q[DEPTH-1:k]);
  end

  assign src_v[0] = in_xfer;
  assign src_d[0] = i_data;

  for (genvar k = 1; k < DEPTH; k++) begin : g_src
    assign src_v[k] = v_q[k-1];
    assign src_d[k] = d_q[k-1];
  end

  assign i_ready  = ld[0] & ~flush;
  assign in_xfer  = i_valid & i_ready;
  assign o_valid  = v_q[DEPTH-1];
  assign o_data   = d_q[DEPTH-1];
  assign out_xfer = o_valid & o_ready;
  assign o_count  = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      v_q   <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ld[k]) v_q[k] <= src_v[k];
      end
      cnt_q <= cnt_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  // Data only moves with a valid entry, so emptied stages keep stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (DATA_RESET_EN) begin
        for (int k = 0; k < DEPTH; k++) d_q[k] <= DATA_RESET_VALUE;
      end
    end else if (!flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ld[k] && src_v[k]) d_q[k] <= src_d[k];
      end
    end
  end

endmodule
